// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and rotation helper for rr_arbiter8
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate an 8-bit vector left by n; a right rotation by p is a left rotation by -p mod 8.
  function automatic logic [NUM_REQ-1:0] rot_left8(input logic [NUM_REQ-1:0] v,
                                                   input logic [ID_W-1:0]    n);
    logic [2*NUM_REQ-1:0] dbl;
    dbl = {v, v} << n;
    return dbl[2*NUM_REQ-1:NUM_REQ];
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// rtl/pri_enc8.sv - combinational first-one finder, lowest set bit wins
module pri_enc8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan from the top down so the lowest set bit is the last assignment and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with optional bounded hold time
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_REQ-1:0]   rot_req;
  logic [ID_W-1:0]      rel_idx;
  logic [ID_W-1:0]      sel_id;
  logic                 any_req;
  logic                 owner_req;
  logic                 hold_lim;

  // Rotate so the pointer position lands on bit 0, find the first one, then undo the rotation.
  assign rot_req = rot_left8(req, 3'd0 - ptr_q);

  pri_enc8 u_pri_enc8 (
    .vec (rot_req),
    .idx (rel_idx),
    .any (any_req)
  );

  assign sel_id    = rel_idx + ptr_q;
  assign owner_req = req[id_q];
  assign hold_lim  = (MAX_HOLD != 0) && (hold_cnt_q == 8'(MAX_HOLD));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: grant when anything is requested and enabled; leave on release or hold limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && any_req) state_d = GRANT;
      GRANT:   if (!owner_req || hold_lim) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next register values for grant, pointer, hold counter and timeout pulse; release beats timeout.
  always_comb begin
    gnt_d      = gnt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (en && any_req) begin
          gnt_d      = NUM_REQ'(1) << sel_id;
          id_d       = sel_id;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          gnt_d = '0;
          ptr_d = id_q + 3'd1;
        end else if (hold_lim) begin
          gnt_d     = '0;
          ptr_d     = id_q + 3'd1;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  // Datapath registers; reset drops any grant without a timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8 with MAX_HOLD=4 and MAX_HOLD=0
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] g4, g0;
  logic [2:0] id4, id0;
  logic       v4, v0, to4, to0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    int owner;
    int ptr;
    int held;
    bit to;
  } model_t;

  model_t m4, m0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(g4), .gnt_id(id4), .gnt_valid(v4), .timeout(to4)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(g0), .gnt_id(id0), .gnt_valid(v0), .timeout(to0)
  );

  function automatic model_t step(model_t m, logic rst, logic e, logic [7:0] r, int mh);
    model_t n;
    bit found;
    n = m;
    n.to = 1'b0;
    if (!rst) begin
      n.owner = -1;
      n.ptr   = 0;
      n.held  = 0;
    end else if (m.owner < 0) begin
      found = 1'b0;
      if (e) begin
        for (int k = 0; k < 8; k++) begin
          if (!found && r[(m.ptr + k) % 8]) begin
            found   = 1'b1;
            n.owner = (m.ptr + k) % 8;
            n.held  = 1;
          end
        end
      end
    end else if (!r[m.owner]) begin
      n.owner = -1;
      n.ptr   = (m.owner + 1) % 8;
    end else if (mh != 0 && m.held >= mh) begin
      n.owner = -1;
      n.ptr   = (m.owner + 1) % 8;
      n.to    = 1'b1;
    end else begin
      n.held = m.held + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string nm, input model_t m, input logic [7:0] g,
                         input logic [2:0] id, input logic v, input logic to);
    logic [7:0] eg;
    eg = (m.owner < 0) ? 8'h00 : (8'h01 << m.owner);
    chk({nm, ".gnt"}, 32'(g), 32'(eg));
    chk({nm, ".gnt_valid"}, 32'(v), 32'(m.owner >= 0));
    chk({nm, ".timeout"}, 32'(to), 32'(m.to));
    if (m.owner >= 0) chk({nm, ".gnt_id"}, 32'(id), 32'(m.owner));
    chk({nm, ".onehot0"}, 32'($onehot0(g)), 32'd1);
    chk({nm, ".valid_eq_or"}, 32'(v), 32'(|g));
    if (v === 1'b1) chk({nm, ".id_matches_gnt"}, 32'(g), 32'(8'h01 << id));
    if (to === 1'b1) chk({nm, ".timeout_no_gnt"}, 32'(g), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = step(m4, rst_n, en, req, 4);
    m0 = step(m0, rst_n, en, req, 0);
    @(negedge clk);
    cmp_dut("d4", m4, g4, id4, v4, to4);
    cmp_dut("d0", m0, g0, id0, v0, to0);
  endtask

  initial begin
    m4 = '{owner: -1, ptr: 0, held: 0, to: 1'b0};
    m0 = '{owner: -1, ptr: 0, held: 0, to: 1'b0};

    // Reset with every requester active.
    rst_n = 1'b0; en = 1'b1; req = 8'hFF;
    tick(); tick();
    chk("reset_gnt", 32'(g4), 32'h00);
    chk("reset_gnt_id", 32'(id4), 32'h0);
    chk("reset_timeout", 32'(to4), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", 32'(g4), 32'h01);

    // Rotation 0..7 and wrap to 0, one idle cycle between grants.
    for (int r = 0; r < 8; r++) begin
      tick(); tick();
      req = 8'hFF & ~(8'h01 << r);
      tick();
      chk("rot_gap", 32'(g4), 32'h00);
      req = 8'hFF;
      tick();
      chk("rot_id", 32'(id4), 32'((r + 1) % 8));
      chk("rot_valid", 32'(v4), 32'h1);
    end

    // Pointer at 3 with only low requesters: scan wraps to 0, then 2.
    req = 8'h00; tick();
    req = 8'h04; tick();
    chk("gap_pre_id", 32'(id4), 32'h2);
    req = 8'h00; tick();
    req = 8'h05; tick();
    chk("gap_wrap_id", 32'(id4), 32'h0);
    chk("gap_wrap_valid", 32'(v4), 32'h1);
    req = 8'h04; tick();
    chk("gap_release", 32'(g4), 32'h00);
    tick();
    chk("gap_next_id", 32'(id4), 32'h2);
    req = 8'h00; tick();

    // Hold limit: four granted cycles, one timeout cycle, then re-grant.
    req = 8'h20; tick();
    chk("to_hold1", 32'(g4), 32'h20);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("to_hold", 32'(g4), 32'h20);
      chk("to_hold_pulse", 32'(to4), 32'h0);
    end
    tick();
    chk("to_pulse", 32'(to4), 32'h1);
    chk("to_pulse_gnt", 32'(g4), 32'h00);
    tick();
    chk("to_regrant", 32'(g4), 32'h20);
    chk("to_pulse_end", 32'(to4), 32'h0);
    for (int c = 0; c < 300; c++) begin
      tick();
      chk("nolimit_gnt", 32'(g0), 32'h20);
      chk("nolimit_timeout", 32'(to0), 32'h0);
    end
    req = 8'h00; tick(); tick();

    // Release in the same cycle the hold limit is reached: no pulse, pointer advances.
    req = 8'h20; tick(); tick(); tick(); tick();
    chk("sim_hold4", 32'(g4), 32'h20);
    req = 8'h00; tick();
    chk("sim_timeout", 32'(to4), 32'h0);
    chk("sim_gnt", 32'(g4), 32'h00);
    req = 8'hFF; tick();
    chk("sim_ptr_id", 32'(id4), 32'h6);

    // Enable low keeps the current grant but blocks the next one.
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("en_keep", 32'(g4), 32'h40);
    end
    req = 8'hBF; tick();
    chk("en_release", 32'(g4), 32'h00);
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("en_block", 32'(g4), 32'h00);
    end
    en = 1'b1; tick();
    chk("en_resume_id", 32'(id4), 32'h7);

    // Reset mid-grant drops the grant and returns the pointer to 0.
    tick();
    rst_n = 1'b0; tick();
    chk("midrst_gnt", 32'(g4), 32'h00);
    chk("midrst_timeout", 32'(to4), 32'h0);
    rst_n = 1'b1; tick();
    chk("midrst_ptr_id", 32'(id4), 32'h0);
    chk("midrst_valid", 32'(v4), 32'h1);

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      req   = req ^ 8'($urandom & $urandom & $urandom);
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
